// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Statistics counters are built only with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } arb_state_e;

  localparam int CNT_W          = 16;
  localparam int DROP_W         = 8;
  localparam int IDX_W          = 3;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  function automatic logic [DROP_W-1:0] sat_inc(
    input logic [DROP_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requester after ptr.
// Outputs a one-hot grant and the matching index.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // Scan farthest to nearest so the nearest match wins.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among producers.
// Define FIFO_ARB_STATS_EN to build the grant/drop counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          almostfull,
  input  logic                          wr_ack,
  input  logic                          overflow,
  output logic [IDX_W-1:0]              grant_id,
  output logic [1:0]                    arb_state,
  output logic                          drop_err,
  output logic [NUM_REQ*CNT_W-1:0]      grant_cnt,
  output logic [DROP_W-1:0]             drop_cnt
);

  logic [IDX_W-1:0]      ptr;
  logic [NUM_REQ-1:0]    pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic [FIFO_WIDTH-1:0] word;
  logic                  blocked;
  logic                  acc;
  logic                  chk;
  logic                  drop_ev;
  arb_state_e            state;

  rr_priority_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(pick_oh),
    .idx  (pick_idx)
  );

  // An in-flight write takes the last free slot.
  assign blocked   = full | (almostfull & wr_en);
  assign acc       = (|req_valid) & ~blocked & ~rst;
  assign req_ready = acc ? pick_oh : '0;
  assign drop_ev   = chk & (overflow | ~wr_ack);
  assign arb_state = state;

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        word = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      data_in  <= '0;
      grant_id <= '0;
      ptr      <= IDX_W'(NUM_REQ - 1);
      chk      <= 1'b0;
      drop_err <= 1'b0;
      state    <= IDLE;
    end else begin
      wr_en <= acc;
      if (acc) begin
        data_in  <= word;
        grant_id <= pick_idx;
        ptr      <= pick_idx;
      end
      // chk marks the cycle in which the FIFO answers a write.
      chk <= wr_en;
      if (drop_ev) begin
        drop_err <= 1'b1;
      end
      unique case (1'b1)
        !(|req_valid): state <= IDLE;
        acc:           state <= ACTIVE;
        default:       state <= STALL;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_W-1:0]  gcnt [NUM_REQ];
  logic [DROP_W-1:0] dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gcnt[i] <= '0;
      end
      dcnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc && pick_oh[i]) begin
          gcnt[i] <= gcnt[i] + 1'b1;
        end
      end
      if (drop_ev) begin
        dcnt <= sat_inc(dcnt);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = gcnt[g];
  end
  assign drop_cnt = dcnt;
`else
  assign grant_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a FIFO model
// and a spec-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  localparam int M_NONE  = 0;
  localparam int M_ALL   = 1;
  localparam int M_RAND  = 2;
  localparam int M_ONLY2 = 3;
  localparam int M_LIST3 = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_STALL  = 2'd2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           wr_en;
  logic [W-1:0]   data_in;
  logic           full;
  logic           almostfull;
  logic           wr_ack;
  logic           overflow;
  logic [2:0]     grant_id;
  logic [1:0]     arb_state;
  logic           drop_err;
  logic [N*16-1:0] grant_cnt;
  logic [7:0]     drop_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .FIFO_WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .full      (full),
    .almostfull(almostfull),
    .wr_ack    (wr_ack),
    .overflow  (overflow),
    .grant_id  (grant_id),
    .arb_state (arb_state),
    .drop_err  (drop_err),
    .grant_cnt (grant_cnt),
    .drop_cnt  (drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t e;
  logic [15:0] p3_list[$];

  int mode;
  bit rd_on;
  bit rd_rand;
  bit rst_req;
  bit arm_force;
  bit post_pulse;
  bit armed;
  int cnt;

  int         m_ptr;
  bit         m_wr;
  bit         m_chk;
  bit         m_drop;
  int         m_dcnt;
  int         m_gcnt[N];
  logic [1:0] m_state;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    logic blk, acc, fo, wacc, rd, n_ack, n_ovf;
    logic [N-1:0] erdy, nv;
    logic [N*W-1:0] nd;
    int w;
    @(negedge clk);
    blk  = full || (almostfull && m_wr);
    acc  = (|req_valid) && !blk && !rst;
    w    = pick(req_valid, m_ptr);
    erdy = '0;
    if (acc) erdy[w] = 1'b1;
    if (armed) begin
      check("req_ready", req_ready, erdy);
      check("wr_en", wr_en, m_wr);
      check("arb_state", arb_state, m_state);
      check("drop_err", drop_err, m_drop);
`ifdef FIFO_ARB_STATS_EN
      check("drop_cnt", drop_cnt, m_dcnt);
      for (int i = 0; i < N; i++)
        check("grant_cnt", grant_cnt[i*16 +: 16], m_gcnt[i] & 'hffff);
`else
      check("drop_cnt", drop_cnt, 0);
      check("grant_cnt", grant_cnt, 0);
`endif
    end
    if (acc) sb.push_back({3'(w), req_data[w*W +: W]});
    if (rst) begin
      m_ptr = N - 1; m_wr = 0; m_chk = 0; m_drop = 0;
      m_dcnt = 0; m_state = S_IDLE;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    end else begin
      if (m_chk && (overflow || !wr_ack)) begin
        m_drop = 1;
        if (m_dcnt < 255) m_dcnt++;
      end
      m_chk = m_wr;
      m_wr  = acc;
      if (acc) begin
        m_ptr = w;
        m_gcnt[w] = (m_gcnt[w] + 1) % 65536;
      end
      m_state = (req_valid == 0) ? S_IDLE : (acc ? S_ACTIVE : S_STALL);
    end
    armed = 1;
    // FIFO environment: depth 8, answers each write next cycle
    fo   = 0;
    wacc = (wr_en === 1'b1) && (cnt < 8);
    if (wr_en === 1'b1 && arm_force) begin
      fo = 1;
      arm_force = 0;
    end
    rd = (rd_on || (rd_rand && $urandom_range(1, 0) == 1)) && cnt > 0;
    cnt   = cnt + int'(wacc) - int'(rd);
    n_ack = wacc && !fo;
    n_ovf = ((wr_en === 1'b1) && !wacc) || fo;
    if (post_pulse) begin
      n_ack = 0;
      n_ovf = 1;
      post_pulse = 0;
    end
    nv = req_valid;
    nd = req_data;
    for (int i = 0; i < N; i++) begin
      if (erdy[i]) nv[i] = 1'b0;
      if (!nv[i]) begin
        case (mode)
          M_ALL: begin
            nv[i] = 1'b1;
            nd[i*W +: W] = 16'($urandom);
          end
          M_RAND: if ($urandom_range(2, 0) == 0) begin
            nv[i] = 1'b1;
            nd[i*W +: W] = 16'($urandom);
          end
          M_ONLY2: if (i == 2) begin
            nv[i] = 1'b1;
            nd[i*W +: W] = 16'($urandom);
          end
          M_LIST3: if (i == 3 && p3_list.size() > 0) begin
            nv[i] = 1'b1;
            nd[i*W +: W] = p3_list.pop_front();
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    rst        = rst_req;
    req_valid  = nv;
    req_data   = nd;
    full       = (cnt == 8);
    almostfull = (cnt == 7);
    wr_ack     = n_ack;
    overflow   = n_ovf;
  endtask

  task automatic drain();
    int k;
    mode  = M_NONE;
    rd_on = 1;
    k = 0;
    while (k < 200 && !(req_valid == 0 && cnt == 0 &&
           wr_en === 1'b0 && sb.size() == 0)) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
    end
  endtask

  always @(negedge clk) begin
    if (armed && wr_en === 1'b1) begin
      check("wr_while_full", full, 1'b0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: wr_en=1 got none expected a write");
      end else begin
        e = sb.pop_front();
        check("grant_id", grant_id, e.id);
        check("data_in", data_in, e.d);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'($urandom);
    full = 0; almostfull = 0; wr_ack = 0; overflow = 0;
    cnt = 0; mode = M_ALL; rd_on = 0; rd_rand = 0;
    rst_req = 1; arm_force = 0; post_pulse = 0; armed = 0;
    m_ptr = N - 1; m_wr = 0; m_chk = 0; m_drop = 0;
    m_dcnt = 0; m_state = S_IDLE;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;

    // two reset cycles with every producer valid, then fill
    tick();
    rst_req = 0;
    repeat (14) tick();
    check("fill_full", full, 1'b1);
    drain();

    // almostfull throttle on producer 2
    cnt   = 6;
    rd_on = 0;
    mode  = M_ONLY2;
    repeat (8) tick();
    rd_on = 1;
    repeat (3) tick();
    drain();

    // single producer, fixed words
    p3_list.push_back(16'hA5A5);
    p3_list.push_back(16'h5A5A);
    mode  = M_LIST3;
    rd_on = 0;
    repeat (6) tick();
    drain();

    // forced overflow on a write
    mode      = M_ALL;
    rd_on     = 1;
    arm_force = 1;
    repeat (10) tick();
    check("drop_sticky", drop_err, 1'b1);

    // reset in the middle of a burst
    rst_req = 1;
    tick();
    check("burst_wr_en", wr_en, 1'b1);
    rst_req    = 0;
    post_pulse = 1;
    tick();
    repeat (6) tick();
    check("drop_after_rst", drop_err, 1'b0);

    // random traffic and random reads
    mode    = M_RAND;
    rd_on   = 0;
    rd_rand = 1;
    repeat (400) begin
      if ($urandom_range(30, 0) == 0) arm_force = 1;
      tick();
    end
    rd_rand = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
